dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
- Memory-stage load/store initiator for the pipeline's byte-addressed data memory.
- Accepts one load/store request from the MEM stage.
- Drives the memory's address, write-data, write-mask and enable pins, and completes the read-valid handshake.
- Returns width-extended load data, or a fault, to the pipeline. Holds the pipeline off via busy/req_ready while a request is in flight.

Parameters:
- DMEM_BYTES, 4096, data memory size in bytes; accesses with any byte at or above this address fault.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present from MEM stage
- req_ready  out  1  unit idle; request accepted when req_valid & req_ready at a clk edge
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low bytes significant
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  qualifies resp_valid: illegal funct3 or out-of-range access
- busy  out  1  state != IDLE
- dmem_address  out  32  memory byte address
- dmem_write_data  out  32  memory write data
- dmem_write_enable  out  1  memory write strobe
- dmem_write_mask  out  4  byte enables; bit k writes address+k
- dmem_read_enable  out  1  memory read request
- dmem_read_data  in  32  memory read data
- dmem_read_valid  in  1  memory read acknowledge

Behaviour:
- All outputs are registered.
- Reset values: every output is 0 except req_ready = 1; state = IDLE.
- Reset mid-operation: return to IDLE next edge and drop all enables. A stray dmem_read_valid after reset is ignored.
- Request capture:
  - On accept, latch write, funct3, addr and wdata.
  - The pipeline need not hold the request afterwards.
  - req_valid is ignored outside IDLE.
- Size: B/BU = 1, H/HU = 2, W = 4.
- Fault conditions, checked at accept:
  - Fault if addr + size > DMEM_BYTES, computed 33-bit so there is no wrap at 0xFFFFFFFF.
  - Fault if funct3 is illegal: 011, 110 or 111 for loads; anything other than 000/001/010 for stores.
  - On fault: no dmem enables ever assert; IDLE -> RESP with resp_fault = 1.
- No alignment restriction. Memory is byte-addressed, so data is never shifted.
- Store masks: B 0001, H 0011, W 1111. dmem_write_data = req_wdata.
- FSM: IDLE, WRITE, READ, CAPTURE, RESP.
  - IDLE: on accepted store -> WRITE with dmem_write_enable = 1. On accepted load -> READ with dmem_read_enable = 1. On fault -> RESP.
  - WRITE: the enable is high for exactly one cycle; -> RESP.
  - READ: hold dmem_read_enable until dmem_read_valid = 1 is sampled, then drop it and go to CAPTURE. dmem_read_data is not yet valid in the read_valid cycle.
  - CAPTURE: the memory presents data this cycle. Sample dmem_read_data, extend it into resp_rdata, and go to RESP.
  - RESP: resp_valid = 1 for one cycle; -> IDLE with req_ready = 1.
- Load extension:
  - B: sign-extend byte 0.
  - H: sign-extend bits 15:0.
  - W: pass through.
  - BU/HU: zero-extend.
- dmem_address and dmem_write_mask stay stable from accept until IDLE. The mask is 0 during loads.
- dmem_write_enable and dmem_read_enable are never high together.
- Latency, with the accepting edge as E0:
  - Store: resp_valid high after E2.
  - Load: read_enable high after E0, read_valid high after E1, data sampled at E3, resp_valid high after E4.
  - Fault: resp_valid high after E1.
- Back-to-back: the next request is accepted in the cycle after resp_valid (req_ready = 1 then).

Test Plan:
- SW 0xDEADBEEF @0x100, then LW @0x100 -> mask 1111 for one cycle; load resp_rdata = 0xDEADBEEF, resp_valid exactly 4 cycles after accept, resp_fault = 0.
- SB 0x000000A5 @0x011, then LB and LBU @0x011 -> mask 0001; LB = 0xFFFFFFA5, LBU = 0x000000A5; bytes 0x010/0x012 unchanged.
- SH 0x00008001 @0x203 (unaligned), then LH and LHU @0x203 -> LH = 0xFFFF8001, LHU = 0x00008001.
- LW @0xFFE, SB @0xFFFFFFFF, load with funct3 = 011 -> each returns resp_fault = 1 one cycle after accept; read and write enables stay 0.
- Assert rst while in READ -> next cycle IDLE, all enables 0, req_ready = 1. A late dmem_read_valid pulse produces no resp_valid. A subsequent LW completes normally.
- req_valid held high across three queued requests -> each accepted only when req_ready = 1; no request dropped or duplicated; busy matches state != IDLE.

Source files
------------

// File: rtl/dmem_access_unit_if.sv
// Request/response and data-memory pin bundle
// for the memory-stage load/store unit.
interface dmem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        busy;
  logic [31:0] dmem_address;
  logic [31:0] dmem_write_data;
  logic        dmem_write_enable;
  logic [3:0]  dmem_write_mask;
  logic        dmem_read_enable;
  logic [31:0] dmem_read_data;
  logic        dmem_read_valid;

  modport slave (
    input  req_valid, req_write, req_funct3,
    input  req_addr, req_wdata,
    input  dmem_read_data, dmem_read_valid,
    output req_ready, resp_valid, resp_rdata,
    output resp_fault, busy,
    output dmem_address, dmem_write_data,
    output dmem_write_enable, dmem_write_mask,
    output dmem_read_enable
  );

  modport master (
    output req_valid, req_write, req_funct3,
    output req_addr, req_wdata,
    output dmem_read_data, dmem_read_valid,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_fault, busy,
    input  dmem_address, dmem_write_data,
    input  dmem_write_enable, dmem_write_mask,
    input  dmem_read_enable
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store initiator: drives the
// byte-addressed data memory, returns extended data.
module dmem_access_unit #(
  parameter int unsigned DMEM_BYTES = 4096
) (
  input logic               clk,
  input logic               rst,
  dmem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CAPTURE,
    RESP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  funct3_q;
  logic        fault_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        we_d;
  logic        re_d;
  logic [2:0]  size;
  logic [32:0] end_addr;
  logic        bad_f3;
  logic        bad_range;
  logic        req_fault;
  logic [3:0]  mask_d;
  logic [31:0] ext;

  // Decode the incoming request: size, legality, store mask.
  always_comb begin
    size   = 3'd1;
    mask_d = 4'b0000;
    unique case (bus.req_funct3[1:0])
      2'b00: size = 3'd1;
      2'b01: size = 3'd2;
      2'b10: size = 3'd4;
      default: size = 3'd1;
    endcase
    if (bus.req_write) begin
      bad_f3 = bus.req_funct3[2]
             | (bus.req_funct3[1:0] == 2'b11);
    end else begin
      bad_f3 = (bus.req_funct3 == 3'b011)
             | (bus.req_funct3[2:1] == 2'b11);
    end
    end_addr  = {1'b0, bus.req_addr}
              + {30'd0, size};
    bad_range = end_addr > 33'(DMEM_BYTES);
    req_fault = bad_f3 | bad_range;
    if (bus.req_write && !req_fault) begin
      unique case (size)
        3'd1: mask_d = 4'b0001;
        3'd2: mask_d = 4'b0011;
        3'd4: mask_d = 4'b1111;
        default: mask_d = 4'b0000;
      endcase
    end
  end

  // Next-state and next-enable logic.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    we_d    = 1'b0;
    re_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (req_fault) begin
            state_d = RESP;
          end else if (bus.req_write) begin
            state_d = WRITE;
            we_d    = 1'b1;
          end else begin
            state_d = READ;
            re_d    = 1'b1;
          end
        end
      end
      WRITE:   state_d = RESP;
      READ: begin
        if (bus.dmem_read_valid) begin
          state_d = CAPTURE;
        end else begin
          re_d = 1'b1;
        end
      end
      CAPTURE: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Width/sign extension of the memory word.
  always_comb begin
    ext = bus.dmem_read_data;
    unique case (1'b1)
      funct3_q == 3'b000:
        ext = {{24{bus.dmem_read_data[7]}},
               bus.dmem_read_data[7:0]};
      funct3_q == 3'b001:
        ext = {{16{bus.dmem_read_data[15]}},
               bus.dmem_read_data[15:0]};
      funct3_q == 3'b100:
        ext = {24'd0, bus.dmem_read_data[7:0]};
      funct3_q == 3'b101:
        ext = {16'd0, bus.dmem_read_data[15:0]};
      default:
        ext = bus.dmem_read_data;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q               <= IDLE;
      funct3_q              <= 3'd0;
      fault_q               <= 1'b0;
      rdata_q               <= 32'd0;
      bus.req_ready         <= 1'b1;
      bus.busy              <= 1'b0;
      bus.resp_valid        <= 1'b0;
      bus.resp_rdata        <= 32'd0;
      bus.resp_fault        <= 1'b0;
      bus.dmem_address      <= 32'd0;
      bus.dmem_write_data   <= 32'd0;
      bus.dmem_write_enable <= 1'b0;
      bus.dmem_write_mask   <= 4'd0;
      bus.dmem_read_enable  <= 1'b0;
    end else begin
      state_q               <= state_d;
      bus.req_ready         <= state_d == IDLE;
      bus.busy              <= state_d != IDLE;
      bus.dmem_write_enable <= we_d;
      bus.dmem_read_enable  <= re_d;
      bus.resp_valid        <= state_q == RESP;
      bus.resp_fault        <= (state_q == RESP)
                             & fault_q;
      bus.resp_rdata        <= (state_q == RESP)
                             ? rdata_q : 32'd0;
      if (accept) begin
        funct3_q            <= bus.req_funct3;
        fault_q             <= req_fault;
        rdata_q             <= 32'd0;
        bus.dmem_address    <= bus.req_addr;
        bus.dmem_write_data <= bus.req_wdata;
        bus.dmem_write_mask <= mask_d;
      end
      if (state_q == CAPTURE) begin
        rdata_q <= ext;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a
// byte-addressed memory model behind it.
module tb_dmem_access_unit;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   both_cnt;

  dmem_access_unit_if bus ();

  dmem_access_unit #(.DMEM_BYTES(4096)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [0:4095];
  logic        mem_rv;
  logic [31:0] mem_rdata;
  logic        mem_hold;
  logic        stray_rv;

  assign bus.dmem_read_valid = mem_rv | stray_rv;
  assign bus.dmem_read_data  = mem_rdata;

  function automatic logic [7:0] rdb(
    input logic [31:0] a
  );
    if (a < 32'd4096) return mem[a[11:0]];
    return 8'h00;
  endfunction

  // Memory: read_valid one cycle after read_enable,
  // data presented the cycle after read_valid.
  always @(posedge clk) begin
    if (rst) begin
      mem_rv    <= 1'b0;
      mem_rdata <= 32'd0;
    end else if (mem_rv) begin
      mem_rv    <= 1'b0;
      mem_rdata <= {rdb(bus.dmem_address + 3),
                    rdb(bus.dmem_address + 2),
                    rdb(bus.dmem_address + 1),
                    rdb(bus.dmem_address)};
    end else if (bus.dmem_read_enable && !mem_hold) begin
      mem_rv <= 1'b1;
    end
    if (bus.dmem_write_enable) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.dmem_write_mask[k] &&
            (bus.dmem_address + k) < 32'd4096) begin
          mem[(bus.dmem_address + k) % 4096]
            <= bus.dmem_write_data[8*k +: 8];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.dmem_write_enable && bus.dmem_read_enable)
      both_cnt++;
  end

  // One request, run to its response (no checks).
  task automatic txn(
    input  logic        w,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        flt,
    output int          lat,
    output int          wec,
    output int          rec,
    output logic [3:0]  wm,
    output int          bad
  );
    rd = 32'hX; flt = 1'bX; lat = -1;
    wec = 0; rec = 0; wm = 4'd0; bad = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    for (int i = 0; i < 20 && !bus.req_ready; i++)
      @(negedge clk);
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_write  = ~w;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.dmem_write_enable) begin
        wec++;
        wm = bus.dmem_write_mask;
        if (bus.dmem_address !== a) bad++;
      end
      if (bus.dmem_read_enable) begin
        rec++;
        if (bus.dmem_address !== a) bad++;
        if (bus.dmem_write_mask !== 4'd0) bad++;
      end
      if (bus.resp_valid) begin
        lat = k;
        rd  = bus.resp_rdata;
        flt = bus.resp_fault;
        break;
      end
    end
  endtask

  logic [31:0] rd;
  logic        flt;
  int          lat, wec, rec, bad;
  logic [3:0]  wm;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_ready got %b want 1",
               bus.req_ready);
    end
    vectors++;
    if ({bus.busy, bus.resp_valid, bus.resp_fault,
         bus.dmem_write_enable, bus.dmem_read_enable}
        !== 5'b0) begin
      miscompares++;
      $display("FAIL rst_flags got %b want 00000",
               {bus.busy, bus.resp_valid,
                bus.resp_fault, bus.dmem_write_enable,
                bus.dmem_read_enable});
    end
    vectors++;
    if ({bus.resp_rdata, bus.dmem_address,
         bus.dmem_write_data, bus.dmem_write_mask}
        !== 100'd0) begin
      miscompares++;
      $display("FAIL rst_buses got %h want 0",
               {bus.resp_rdata, bus.dmem_address,
                bus.dmem_write_data,
                bus.dmem_write_mask});
    end
  endtask

  task automatic test_word();
    txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF,
        rd, flt, lat, wec, rec, wm, bad);
    vectors++;
    if (lat !== 2 || flt !== 1'b0 ||
        rd !== 32'd0) begin
      miscompares++;
      $display("FAIL sw_resp got lat %0d f %b d %h want 2 0 0",
               lat, flt, rd);
    end
    vectors++;
    if (wec !== 1 || wm !== 4'b1111 ||
        rec !== 0 || bad !== 0) begin
      miscompares++;
      $display("FAIL sw_pins got we %0d m %b re %0d bad %0d want 1 1111 0 0",
               wec, wm, rec, bad);
    end
    vectors++;
    if ({mem[12'h103], mem[12'h102], mem[12'h101],
         mem[12'h100]} !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL sw_mem got %h want deadbeef",
               {mem[12'h103], mem[12'h102],
                mem[12'h101], mem[12'h100]});
    end
    txn(1'b0, 3'b010, 32'h100, 32'h0,
        rd, flt, lat, wec, rec, wm, bad);
    vectors++;
    if (rd !== 32'hDEADBEEF || lat !== 4 ||
        flt !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_resp got %h lat %0d f %b want deadbeef 4 0",
               rd, lat, flt);
    end
    vectors++;
    if (wec !== 0 || rec !== 2 || bad !== 0) begin
      miscompares++;
      $display("FAIL lw_pins got we %0d re %0d bad %0d want 0 2 0",
               wec, rec, bad);
    end
  endtask

  task automatic test_byte();
    txn(1'b1, 3'b000, 32'h010, 32'h00000011,
        rd, flt, lat, wec, rec, wm, bad);
    txn(1'b1, 3'b000, 32'h012, 32'h00000022,
        rd, flt, lat, wec, rec, wm, bad);
    txn(1'b1, 3'b000, 32'h011, 32'h777777A5,
        rd, flt, lat, wec, rec, wm, bad);
    vectors++;
    if (wm !== 4'b0001 || wec !== 1 ||
        lat !== 2) begin
      miscompares++;
      $display("FAIL sb_pins got m %b we %0d lat %0d want 0001 1 2",
               wm, wec, lat);
    end
    vectors++;
    if ({mem[12'h012], mem[12'h011], mem[12'h010]}
        !== 24'h22A511) begin
      miscompares++;
      $display("FAIL sb_mem got %h want 22a511",
               {mem[12'h012], mem[12'h011],
                mem[12'h010]});
    end
    txn(1'b0, 3'b000, 32'h011, 32'h0,
        rd, flt, lat, wec, rec, wm, bad);
    vectors++;
    if (rd !== 32'hFFFFFFA5 || lat !== 4) begin
      miscompares++;
      $display("FAIL lb got %h lat %0d want ffffffa5 4",
               rd, lat);
    end
    txn(1'b0, 3'b100, 32'h011, 32'h0,
        rd, flt, lat, wec, rec, wm, bad);
    vectors++;
    if (rd !== 32'h000000A5 || flt !== 1'b0) begin
      miscompares++;
      $display("FAIL lbu got %h f %b want 000000a5 0",
               rd, flt);
    end
  endtask

  task automatic test_half();
    txn(1'b1, 3'b001, 32'h203, 32'h00008001,
        rd, flt, lat, wec, rec, wm, bad);
    vectors++;
    if (wm !== 4'b0011 || flt !== 1'b0 ||
        bad !== 0) begin
      miscompares++;
      $display("FAIL sh_pins got m %b f %b bad %0d want 0011 0 0",
               wm, flt, bad);
    end
    txn(1'b0, 3'b001, 32'h203, 32'h0,
        rd, flt, lat, wec, rec, wm, bad);
    vectors++;
    if (rd !== 32'hFFFF8001) begin
      miscompares++;
      $display("FAIL lh got %h want ffff8001", rd);
    end
    txn(1'b0, 3'b101, 32'h203, 32'h0,
        rd, flt, lat, wec, rec, wm, bad);
    vectors++;
    if (rd !== 32'h00008001) begin
      miscompares++;
      $display("FAIL lhu got %h want 00008001", rd);
    end
  endtask

  task automatic test_fault();
    logic        tw [5];
    logic [2:0]  tf [5];
    logic [31:0] ta [5];
    tw = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tf = '{3'b010, 3'b000, 3'b011, 3'b100, 3'b010};
    ta = '{32'hFFE, 32'hFFFFFFFF, 32'h0, 32'h0,
           32'hFFE};
    for (int i = 0; i < 5; i++) begin
      txn(tw[i], tf[i], ta[i], 32'h12345678,
          rd, flt, lat, wec, rec, wm, bad);
      vectors++;
      if (flt !== 1'b1 || lat !== 1 ||
          rd !== 32'd0 || wec !== 0 || rec !== 0) begin
        miscompares++;
        $display("FAIL fault_%0d got f %b lat %0d d %h we %0d re %0d want 1 1 0 0 0",
                 i, flt, lat, rd, wec, rec);
      end
    end
    txn(1'b1, 3'b010, 32'hFFC, 32'h01020304,
        rd, flt, lat, wec, rec, wm, bad);
    vectors++;
    if (flt !== 1'b0 || lat !== 2 || wec !== 1) begin
      miscompares++;
      $display("FAIL sw_top got f %b lat %0d we %0d want 0 2 1",
               flt, lat, wec);
    end
    txn(1'b0, 3'b010, 32'hFFC, 32'h0,
        rd, flt, lat, wec, rec, wm, bad);
    vectors++;
    if (rd !== 32'h01020304 || flt !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_top got %h f %b want 01020304 0",
               rd, flt);
    end
  endtask

  task automatic test_reset_mid();
    int rv_seen;
    mem_hold = 1'b1;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h100;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.dmem_read_enable !== 1'b1 ||
        bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_read got re %b busy %b want 1 1",
               bus.dmem_read_enable, bus.busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.dmem_read_enable, bus.dmem_write_enable,
         bus.req_ready, bus.busy, bus.resp_valid}
        !== 5'b00100) begin
      miscompares++;
      $display("FAIL rst_mid got %b want 00100",
               {bus.dmem_read_enable,
                bus.dmem_write_enable, bus.req_ready,
                bus.busy, bus.resp_valid});
    end
    mem_hold = 1'b0;
    stray_rv = 1'b1;
    @(posedge clk);
    #1 stray_rv = 1'b0;
    rv_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.resp_valid || bus.busy ||
          bus.dmem_read_enable) rv_seen++;
    end
    vectors++;
    if (rv_seen !== 0) begin
      miscompares++;
      $display("FAIL stray_rv got %0d cycles active want 0",
               rv_seen);
    end
    txn(1'b0, 3'b010, 32'h100, 32'h0,
        rd, flt, lat, wec, rec, wm, bad);
    vectors++;
    if (rd !== 32'hDEADBEEF || lat !== 4 ||
        flt !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_after_rst got %h lat %0d f %b want deadbeef 4 0",
               rd, lat, flt);
    end
  endtask

  task automatic test_back_to_back();
    logic        qw [3];
    logic [2:0]  qf [3];
    logic [31:0] qa [3];
    logic [31:0] qe [3];
    int          ql [3];
    int nxt, cur, k, done, acc_cnt;
    logic acc, inflight, eb, ev;
    qw = '{1'b1, 1'b0, 1'b0};
    qf = '{3'b010, 3'b010, 3'b100};
    qa = '{32'h300, 32'h300, 32'h303};
    qe = '{32'h0, 32'h11223344, 32'h00000011};
    ql = '{2, 4, 4};
    nxt = 0; cur = 0; k = 0; done = 0;
    acc_cnt = 0; inflight = 1'b0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = qw[0];
    bus.req_funct3 = qf[0];
    bus.req_addr   = qa[0];
    bus.req_wdata  = 32'h11223344;
    for (int c = 0; c < 60 && done < 3; c++) begin
      acc = bus.req_valid && bus.req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        cur = nxt;
        nxt++;
        k = 0;
        inflight = 1'b1;
        acc_cnt++;
        if (nxt < 3) begin
          bus.req_write  = qw[nxt];
          bus.req_funct3 = qf[nxt];
          bus.req_addr   = qa[nxt];
          bus.req_wdata  = $urandom;
        end else begin
          bus.req_valid = 1'b0;
        end
      end else if (inflight) begin
        k++;
      end
      @(negedge clk);
      eb = inflight && (k < ql[cur]);
      ev = inflight && (k == ql[cur]);
      vectors++;
      if (bus.busy !== eb) begin
        miscompares++;
        $display("FAIL b2b_busy c%0d got %b want %b",
                 c, bus.busy, eb);
      end
      vectors++;
      if (bus.req_ready !== !eb) begin
        miscompares++;
        $display("FAIL b2b_ready c%0d got %b want %b",
                 c, bus.req_ready, !eb);
      end
      vectors++;
      if (bus.resp_valid !== ev) begin
        miscompares++;
        $display("FAIL b2b_resp c%0d got %b want %b",
                 c, bus.resp_valid, ev);
      end
      if (ev) begin
        vectors++;
        if (bus.resp_rdata !== qe[cur]) begin
          miscompares++;
          $display("FAIL b2b_data_%0d got %h want %h",
                   cur, bus.resp_rdata, qe[cur]);
        end
        done++;
        inflight = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    vectors++;
    if (done !== 3 || acc_cnt !== 3) begin
      miscompares++;
      $display("FAIL b2b_count got %0d resp %0d acc want 3 3",
               done, acc_cnt);
    end
  endtask

  task automatic test_exclusive();
    vectors++;
    if (both_cnt !== 0) begin
      miscompares++;
      $display("FAIL enables_both got %0d cycles want 0",
               both_cnt);
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    both_cnt       = 0;
    rst            = 1'b1;
    mem_hold       = 1'b0;
    stray_rv       = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
